// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's load/store handshake into the shared data memory
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  modport master(output req, we, size, uns, addr, wdata, input done, err, rdata);
  modport slave(input req, we, size, uns, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port access to a word memory with sub-word load extension and RMW stores
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
  state_t state;
  logic last_grant, gnt, we_q, uns_q, pick, sel_we, sel_uns, sel_err, word_st, sub_st;
  logic [1:0] size_q, sel_size, done_q, err_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q, old_q, sel_addr, sel_wdata, lane, mask, merged, shifted, load_val;
  logic [1:0][31:0] rdata_q;
  logic [4:0] sh;
  assign pick = (p0.req && p1.req) ? ~last_grant : p1.req;
  assign sel_we = pick ? p1.we : p0.we;
  assign sel_uns = pick ? p1.uns : p0.uns;
  assign sel_size = pick ? p1.size : p0.size;
  assign sel_addr = pick ? p1.addr : p0.addr;
  assign sel_wdata = pick ? p1.wdata : p0.wdata;
  assign sel_err = (sel_size == 2'b11) || (sel_size == 2'b01 && sel_addr[0]) ||
                   (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(4 * DEPTH));
  assign word_st = we_q && size_q == 2'b10;
  assign sub_st = we_q && !size_q[1];
  // Lane offset in bits: byte at addr[1:0], half at addr[1], little-endian
  assign sh = size_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
  assign lane = size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign mask = lane << sh;
  assign merged = (old_q & ~mask) | ((wdata_q << sh) & mask);
  assign shifted = mem_rdata >> sh;
  assign load_val = size_q[1] ? mem_rdata :
                    size_q[0] ? {uns_q ? 16'h0 : {16{shifted[15]}}, shifted[15:0]} :
                                {uns_q ? 24'h0 : {24{shifted[7]}}, shifted[7:0]};
  assign mem_rd_en = state == ACCESS && !word_st;
  assign mem_wr_en = rst_n && ((state == ACCESS && word_st) || state == RMW_WR);
  assign mem_addr = (state == ACCESS || state == RMW_WR) ? {{(32 - AW){1'b0}}, addr_q[AW+1:2]} : '0;
  assign mem_wdata = state == RMW_WR ? merged : (state == ACCESS && word_st) ? wdata_q : '0;
  assign busy = state != IDLE;
  assign p0.done = done_q[0];
  assign p1.done = done_q[1];
  assign p0.err = err_q[0];
  assign p1.err = err_q[1];
  assign p0.rdata = rdata_q[0];
  assign p1.rdata = rdata_q[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      done_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: if (p0.req || p1.req) begin
          gnt <= pick;
          last_grant <= pick;
          we_q <= sel_we;
          uns_q <= sel_uns;
          size_q <= sel_size;
          addr_q <= sel_addr[AW+1:0];
          wdata_q <= sel_wdata;
          state <= sel_err ? RESP : ACCESS;
          done_q[pick] <= sel_err;
          err_q[pick] <= sel_err;
        end
        ACCESS: begin
          if (!we_q) rdata_q[gnt] <= load_val;
          old_q <= mem_rdata;
          state <= sub_st ? RMW_WR : RESP;
          done_q[gnt] <= !sub_st;
        end
        RMW_WR: begin
          state <= RESP;
          done_q[gnt] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-port traffic against a byte-level memory model and round-robin grant model
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter_if pif0();
  dmem_arbiter_if pif1();
  logic mem_rd_en, mem_wr_en, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic req [2];
  logic we [2];
  logic uns [2];
  logic [1:0] size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic dn [2];
  logic er [2];
  logic [31:0] rd [2];
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rd [2];
  logic lg;
  int checks = 0;
  int errors = 0;
  assign pif0.req = req[0];
  assign pif0.we = we[0];
  assign pif0.size = size[0];
  assign pif0.uns = uns[0];
  assign pif0.addr = addr[0];
  assign pif0.wdata = wdata[0];
  assign pif1.req = req[1];
  assign pif1.we = we[1];
  assign pif1.size = size[1];
  assign pif1.uns = uns[1];
  assign pif1.addr = addr[1];
  assign pif1.wdata = wdata[1];
  assign dn[0] = pif0.done;
  assign dn[1] = pif1.done;
  assign er[0] = pif0.err;
  assign er[1] = pif1.err;
  assign rd[0] = pif0.rdata;
  assign rd[1] = pif1.rdata;
  dmem_arbiter #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .p0(pif0), .p1(pif1),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(negedge clk) if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit bad(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || a >= 32'(4 * DEPTH);
  endfunction
  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]] >> (8 * a[1:0]);
    return w[7:0];
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = 1 << s;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
    if (!u && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction
  function automatic void ref_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) begin
      logic [31:0] b;
      b = a + 32'(i);
      ref_mem[b[11:2]][8 * b[1:0] +: 8] = d[8 * i +: 8];
    end
  endfunction
  task automatic run(input int n, input bit hold);
    bit pend [2];
    int w, cyc, nrd, nwr, lat, idx, left;
    bit e, sub, got;
    pend[0] = req[0];
    pend[1] = req[1];
    left = n;
    while ((pend[0] || pend[1]) && left > 0) begin
      w = (pend[0] && pend[1]) ? (lg ? 0 : 1) : (pend[0] ? 0 : 1);
      lg = (w == 1);
      e = bad(size[w], addr[w]);
      sub = we[w] && size[w] < 2'd2;
      lat = e ? 1 : sub ? 3 : 2;
      idx = int'(addr[w][11:2]);
      cyc = 0;
      nrd = 0;
      nwr = 0;
      got = 0;
      while (!got && cyc < 8) begin
        @(negedge clk);
        cyc++;
        if (mem_rd_en) nrd++;
        if (mem_wr_en) begin
          nwr++;
          chk("wr_addr", mem_addr, 32'(idx));
        end
        got = dn[0] || dn[1];
      end
      chk("latency", 32'(cyc), 32'(lat + 1));
      chk("done_win", 32'(dn[w]), 32'd1);
      chk("done_other", 32'(dn[1 - w]), 32'd0);
      chk("err", 32'(er[w]), 32'(e));
      chk("rd_pulses", 32'(nrd), (!e && (!we[w] || sub)) ? 32'd1 : 32'd0);
      chk("wr_pulses", 32'(nwr), (!e && we[w]) ? 32'd1 : 32'd0);
      if (!e && !we[w]) exp_rd[w] = ref_load(size[w], uns[w], addr[w]);
      if (!e && we[w]) begin
        ref_store(size[w], addr[w], wdata[w]);
        chk("mem_word", mem[idx], ref_mem[idx]);
      end
      chk("rdata0", rd[0], exp_rd[0]);
      chk("rdata1", rd[1], exp_rd[1]);
      left--;
      if (!hold) begin
        pend[w] = 0;
        req[w] = 1'b0;
      end
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int p, input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] d);
    we[p] = w;
    size[p] = s;
    uns[p] = u;
    addr[p] = a;
    wdata[p] = d;
    req[p] = 1'b1;
    run(1, 1'b0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lg = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask
  task automatic rst_mid(input int extra);
    we[0] = 1'b1;
    size[0] = 2'd0;
    uns[0] = 1'b0;
    addr[0] = 32'h14;
    wdata[0] = ~ref_mem[5];
    req[0] = 1'b1;
    repeat (extra) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy_mid", 32'(busy), 32'd1);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_mem", mem[5], ref_mem[5]);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lg = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask
  task automatic rand_port(input int p);
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 15);
    we[p] = 1'($urandom_range(0, 1));
    uns[p] = 1'($urandom_range(0, 1));
    size[p] = (k == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    wdata[p] = $urandom;
    a = 32'($urandom_range(0, 15)) << 2;
    if (k == 2) a = 32'($urandom_range(DEPTH - 4, DEPTH - 1)) << 2;
    if (size[p] == 2'd0 || k == 3) a[1:0] = 2'($urandom_range(0, 3));
    else if (size[p] == 2'd1) a[1] = 1'($urandom_range(0, 1));
    if (k == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
    if (k == 4) a = $urandom | 32'h8000_0000;
    addr[p] = a;
  endtask
  initial begin
    int r;
    bit hold;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0;
      we[p] = 1'b0;
      uns[p] = 1'b0;
      size[p] = 2'd0;
      addr[p] = '0;
      wdata[p] = '0;
      exp_rd[p] = '0;
    end
    lg = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", {30'd0, dn[1], dn[0]}, 32'd0);
    chk("reset_err", {30'd0, er[1], er[0]}, 32'd0);
    chk("reset_rdata0", rd[0], 32'd0);
    chk("reset_rdata1", rd[1], 32'd0);
    chk("reset_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    go(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("word_load", rd[0], 32'hDEADBEEF);
    go(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    go(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000A5);
    chk("byte_merge", mem[4], 32'h11A53344);
    go(0, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    chk("byte_signed", rd[0], 32'hFFFFFFA5);
    go(1, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    chk("byte_unsigned", rd[1], 32'h000000A5);
    go(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFE);
    go(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("half_hi_signed", rd[0], 32'hFFFF8001);
    go(1, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    chk("half_lo_signed", rd[1], 32'h00007FFE);
    go(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    go(1, 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
    go(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h1);
    go(1, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h1);
    chk("err_no_write", mem[4], 32'h80017FFE);
    do_reset();
    for (int p = 0; p < 2; p++) begin
      we[p] = 1'b0;
      size[p] = 2'd2;
      addr[p] = 32'(16 + 16 * p);
      req[p] = 1'b1;
    end
    run(4, 1'b1);
    rst_mid(1);
    rst_mid(2);
    for (int it = 0; it < 250; it++) begin
      rand_port(0);
      rand_port(1);
      r = $urandom_range(0, 2);
      req[0] = (r != 1);
      req[1] = (r != 0);
      hold = (r == 2) && ($urandom_range(0, 5) == 0);
      run(hold ? 5 : 2, hold);
      if ($urandom_range(0, 40) == 0) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
